drink_dispenser: RTL and testbench
==================================

// Module: drink_dispenser
// PURPOSE
//  Consumer end of the drink-menu handshake: accepts the menu's selection outputs (B1..B4),
//  decodes the chosen drink, sequences cup drop, timed valve pour and drip phases, then
//  pulses clc back to the menu so it returns to the first option. Same clk domain as the menu.
// PARAMETERS
//  TIMER_W      8   width of the phase down-counter
//  CUP_CYCLES   4   cycles cup_drop is held high (>=1)
//  POUR1_CYCLES 20  pour length, drink 1 (>=1)
//  POUR2_CYCLES 30  pour length, drink 2 (>=1)
//  POUR3_CYCLES 40  pour length, drink 3 (>=1)
//  POUR4_CYCLES 50  pour length, drink 4 (>=1)
//  DRIP_CYCLES  6   settle time after valve closes (>=1)
//  PAY_TIMEOUT  100 cycles to wait for coin_ok (only with COIN_CHECK_EN)
// PORTS
//  clk       in   1  clock, rising edge
//  reset     in   1  asynchronous, active-high
//  b1,b2,b3  in   1  menu selection lines
//  b4        in   1  menu "selection valid" (high in every selected state)
//  coin_ok   in   1  payment accepted (present only with COIN_CHECK_EN)
//  cup_drop  out  1  cup solenoid
//  valve     out  4  one-hot pour valve, bit n-1 = drink n
//  busy      out  1  high in every state except IDLE
//  clc       out  1  one-cycle clear pulse to menu
//  err       out  1  one-cycle pulse on invalid code, abort or payment timeout
// BEHAVIOUR
//  Reset: state IDLE, timer 0; cup_drop, valve, busy, clc, err all 0 immediately (async),
//   including mid-pour. All outputs registered; no combinational input-to-output path.
//  Decode (sampled in IDLE when b4=1): {b3,b2,b1}=001->drink1, 010->2, 100->3, 000->4;
//   any other pattern -> invalid: err pulse, go ACK without dispensing. b4=0: stay IDLE.
//  States: IDLE -> [PAY] -> CUP -> POUR -> DRIP -> ACK -> WAIT_REL -> IDLE.
//  Phase timing: timer loads N-1 on entry, phase lasts exactly N cycles, exits at timer==0.
//  Latency: b4 high at edge k -> cup_drop=1 after edge k for CUP_CYCLES cycles;
//   valve[d-1]=1 for POURd_CYCLES immediately after; then DRIP with all outputs 0 but busy.
//  Drink code latched on leaving IDLE; b1..b3 changes afterwards ignored.
//  Abort: b4=0 in CUP/POUR/DRIP (menu reset) -> next edge valve=0, cup_drop=0, err pulse,
//   go IDLE (no clc).
//  ACK: clc=1 for exactly one cycle, then WAIT_REL.
//  WAIT_REL: hold until b4=0, then IDLE; no re-trigger while selection still held.
//  Simultaneous: reset dominates all; abort check takes priority over timer expiry.
//  busy=1 in all states but IDLE; valve never has more than one bit set.
// CONFIGURATION
//  COIN_CHECK_EN defined: coin_ok port exists; PAY state between IDLE and CUP; coin_ok=1
//   -> CUP next edge; PAY_TIMEOUT cycles without coin_ok -> err pulse, ACK (clc, no pour);
//   b4=0 in PAY -> abort rule.
//  Not defined: no coin_ok port, no PAY state; IDLE goes straight to CUP.
// STRUCTURE
//  drink_pkg: state enum (IDLE,PAY,CUP,POUR,DRIP,ACK,WAIT_REL), drink_t (2-bit code),
//   valve one-hot constants, decode function {b3,b2,b1}->drink_t/invalid.
//  Sub-module phase_timer: loadable TIMER_W down-counter, load/value inputs, zero flag.
//  Top: FSM, drink latch, output registers, pour-length mux by drink code.
// TESTING
//  b4=1,b2=1 one cycle then held -> cup_drop 4 cyc, valve=0010 30 cyc, drip 6, clc 1 cyc.
//  b4=1, b1..b3=000 -> valve=1000 for 50 cycles; clc pulse once; no err.
//  b4=1,b1=1,b3=1 -> err pulse, clc pulse next, valve stays 0000, cup_drop stays 0.
//  b4 dropped at pour cycle 10 -> valve=0000 next edge, err=1 one cycle, back IDLE, no clc.
//  reset asserted mid-pour -> valve, busy 0 without clock edge; b4 held after -> new cycle.
//  COIN_CHECK_EN: coin_ok never set -> err + clc after 100 cycles; coin_ok at 5 -> cup next.

Source files
------------

// File: rtl/drink_pkg.sv
// Shared types for the drink dispenser: FSM states, drink codes, valve encodings
// and the decode of the menu selection lines.
package drink_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PAY,
        CUP,
        POUR,
        DRIP,
        ACK,
        WAIT_REL
    } state_t;

    typedef logic [1:0] drink_t;

    localparam drink_t DRINK1 = 2'd0;
    localparam drink_t DRINK2 = 2'd1;
    localparam drink_t DRINK3 = 2'd2;
    localparam drink_t DRINK4 = 2'd3;

    localparam logic [3:0] VALVE_D1 = 4'b0001;
    localparam logic [3:0] VALVE_D2 = 4'b0010;
    localparam logic [3:0] VALVE_D3 = 4'b0100;
    localparam logic [3:0] VALVE_D4 = 4'b1000;

    typedef struct packed {
        logic   valid;
        drink_t drink;
    } sel_t;

    // The menu reports drink 4 as "valid with no selection line set".
    function automatic sel_t decode_sel(input logic b3, input logic b2, input logic b1);
        sel_t s;
        s.valid = 1'b1;
        s.drink = DRINK1;
        case ({b3, b2, b1})
            3'b001:  s.drink = DRINK1;
            3'b010:  s.drink = DRINK2;
            3'b100:  s.drink = DRINK3;
            3'b000:  s.drink = DRINK4;
            default: s.valid = 1'b0;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] valve_of(input drink_t d);
        logic [3:0] v;
        case (d)
            DRINK1:  v = VALVE_D1;
            DRINK2:  v = VALVE_D2;
            DRINK3:  v = VALVE_D3;
            default: v = VALVE_D4;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter used to time each dispenser phase; stops at zero.
module phase_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic [W-1:0] count,
    output logic         zero
);

    assign zero = (count == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= value;
        else if (!zero)
            count <= count - 1'b1;
    end

endmodule

// File: rtl/drink_dispenser.sv
// Drink dispenser FSM: decodes the menu selection, drops a cup, pours, drips and
// pulses clc back to the menu. Define COIN_CHECK_EN to add the coin_ok payment phase.
module drink_dispenser
    import drink_pkg::*;
#(
    parameter int TIMER_W      = 8,
    parameter int CUP_CYCLES   = 4,
    parameter int POUR1_CYCLES = 20,
    parameter int POUR2_CYCLES = 30,
    parameter int POUR3_CYCLES = 40,
    parameter int POUR4_CYCLES = 50,
    parameter int DRIP_CYCLES  = 6,
    parameter int PAY_TIMEOUT  = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       b1,
    input  logic       b2,
    input  logic       b3,
    input  logic       b4,
`ifdef COIN_CHECK_EN
    input  logic       coin_ok,
`endif
    output logic       cup_drop,
    output logic [3:0] valve,
    output logic       busy,
    output logic       clc,
    output logic       err
);

`ifdef COIN_CHECK_EN
    localparam logic COIN_EN = 1'b1;
    logic pay_ok;
    assign pay_ok = coin_ok;
`else
    localparam logic COIN_EN = 1'b0;
    logic pay_ok;
    assign pay_ok = 1'b0;
`endif

    state_t               state, next_state;
    drink_t               drink_q;
    sel_t                 sel;
    logic                 latch_drink;
    logic                 next_err;
    logic                 timer_load;
    logic [TIMER_W-1:0]   timer_val;
    logic [TIMER_W-1:0]   timer_count;
    logic                 timer_zero;
    logic [TIMER_W-1:0]   pour_len;

    phase_timer #(.W(TIMER_W)) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (timer_load),
        .value (timer_val),
        .count (timer_count),
        .zero  (timer_zero)
    );

    always_comb begin
        case (drink_q)
            DRINK1:  pour_len = TIMER_W'(POUR1_CYCLES - 1);
            DRINK2:  pour_len = TIMER_W'(POUR2_CYCLES - 1);
            DRINK3:  pour_len = TIMER_W'(POUR3_CYCLES - 1);
            default: pour_len = TIMER_W'(POUR4_CYCLES - 1);
        endcase
    end

    assign sel = decode_sel(b3, b2, b1);

    // Abort (b4 dropped) is tested before timer expiry in every timed phase.
    always_comb begin
        next_state  = state;
        latch_drink = 1'b0;
        next_err    = 1'b0;
        timer_load  = 1'b0;
        timer_val   = '0;
        case (state)
            IDLE: begin
                if (b4) begin
                    latch_drink = 1'b1;
                    if (!sel.valid) begin
                        next_state = ACK;
                        next_err   = 1'b1;
                    end else if (COIN_EN) begin
                        next_state = PAY;
                        timer_load = 1'b1;
                        timer_val  = TIMER_W'(PAY_TIMEOUT - 1);
                    end else begin
                        next_state = CUP;
                        timer_load = 1'b1;
                        timer_val  = TIMER_W'(CUP_CYCLES - 1);
                    end
                end
            end
            PAY: begin
                if (!b4) begin
                    next_state = IDLE;
                    next_err   = 1'b1;
                end else if (pay_ok) begin
                    next_state = CUP;
                    timer_load = 1'b1;
                    timer_val  = TIMER_W'(CUP_CYCLES - 1);
                end else if (timer_zero) begin
                    next_state = ACK;
                    next_err   = 1'b1;
                end
            end
            CUP: begin
                if (!b4) begin
                    next_state = IDLE;
                    next_err   = 1'b1;
                end else if (timer_zero) begin
                    next_state = POUR;
                    timer_load = 1'b1;
                    timer_val  = pour_len;
                end
            end
            POUR: begin
                if (!b4) begin
                    next_state = IDLE;
                    next_err   = 1'b1;
                end else if (timer_zero) begin
                    next_state = DRIP;
                    timer_load = 1'b1;
                    timer_val  = TIMER_W'(DRIP_CYCLES - 1);
                end
            end
            DRIP: begin
                if (!b4) begin
                    next_state = IDLE;
                    next_err   = 1'b1;
                end else if (timer_zero) begin
                    next_state = ACK;
                end
            end
            ACK:      next_state = WAIT_REL;
            WAIT_REL: if (!b4) next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            drink_q  <= DRINK1;
            cup_drop <= 1'b0;
            valve    <= 4'b0000;
            busy     <= 1'b0;
            clc      <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= next_state;
            if (latch_drink)
                drink_q <= sel.drink;
            cup_drop <= (next_state == CUP);
            valve    <= (next_state == POUR) ? valve_of(drink_q) : 4'b0000;
            busy     <= (next_state != IDLE);
            clc      <= (state == ACK);
            err      <= next_err;
        end
    end

endmodule

// File: tb/tb_drink_dispenser.sv
// Directed self-checking bench for drink_dispenser; covers the coin_ok phase when
// built with COIN_CHECK_EN.
module tb_drink_dispenser;

    logic       clk;
    logic       reset;
    logic       b1, b2, b3, b4;
`ifdef COIN_CHECK_EN
    logic       coin_ok;
`endif
    logic       cup_drop;
    logic [3:0] valve;
    logic       busy;
    logic       clc;
    logic       err;

    int checks;
    int fails;

    // Observed vector layout: {cup_drop, valve[3:0], busy, clc, err}
    localparam logic [7:0] O_IDLE     = 8'b0_0000_0_0_0;
    localparam logic [7:0] O_CUP      = 8'b1_0000_1_0_0;
    localparam logic [7:0] O_BUSY     = 8'b0_0000_1_0_0;
    localparam logic [7:0] O_CLC      = 8'b0_0000_1_1_0;
    localparam logic [7:0] O_ERR_IDLE = 8'b0_0000_0_0_1;
    localparam logic [7:0] O_ERR_BUSY = 8'b0_0000_1_0_1;
    localparam logic [7:0] O_POUR1    = 8'b0_0001_1_0_0;
    localparam logic [7:0] O_POUR2    = 8'b0_0010_1_0_0;
    localparam logic [7:0] O_POUR3    = 8'b0_0100_1_0_0;
    localparam logic [7:0] O_POUR4    = 8'b0_1000_1_0_0;

    drink_dispenser dut (
        .clk      (clk),
        .reset    (reset),
        .b1       (b1),
        .b2       (b2),
        .b3       (b3),
        .b4       (b4),
`ifdef COIN_CHECK_EN
        .coin_ok  (coin_ok),
`endif
        .cup_drop (cup_drop),
        .valve    (valve),
        .busy     (busy),
        .clc      (clc),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic s4, input logic s3, input logic s2, input logic s1);
        b4 = s4;
        b3 = s3;
        b2 = s2;
        b1 = s1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] expected);
        logic [7:0] observed;
        observed = {cup_drop, valve, busy, clc, err};
        checks++;
        assert (observed === expected)
        else begin
            fails++;
            $error("[TB] FAIL %s observed=%b expected=%b (cup,valve,busy,clc,err)",
                   tag, observed, expected);
        end
    endtask

    task automatic expectRun(input string tag, input int n, input logic [7:0] expected);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checkOutput(tag, expected);
        end
    endtask

    // One extra PAY cycle exists when the coin check is built in (coin_ok held high).
    task automatic payPhase(input string tag);
`ifdef COIN_CHECK_EN
        expectRun(tag, 1, O_BUSY);
`else
        checkOutput(tag, O_IDLE);
`endif
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        reset  = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
`ifdef COIN_CHECK_EN
        coin_ok = 1'b1;
`endif
        #3;
        checkOutput("reset state", O_IDLE);
        @(negedge clk);
        reset = 1'b0;
        expectRun("idle b4 low", 3, O_IDLE);

        // Drink 2; b2 released after the cup phase, code must stay latched.
        $display("[TB] drink 2 sequence");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        payPhase("d2 pay");
        expectRun("d2 cup", 4, O_CUP);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        expectRun("d2 pour", 30, O_POUR2);
        expectRun("d2 drip+ack", 7, O_BUSY);
        expectRun("d2 clc", 1, O_CLC);
        expectRun("d2 wait_rel", 3, O_BUSY);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        expectRun("d2 back idle", 2, O_IDLE);

        // Drink 4 (no selection line set)
        $display("[TB] drink 4 sequence");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        payPhase("d4 pay");
        expectRun("d4 cup", 4, O_CUP);
        expectRun("d4 pour", 50, O_POUR4);
        expectRun("d4 drip+ack", 7, O_BUSY);
        expectRun("d4 clc", 1, O_CLC);
        expectRun("d4 wait_rel", 2, O_BUSY);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        expectRun("d4 back idle", 2, O_IDLE);

        // Invalid code b1+b3
        $display("[TB] invalid code");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        expectRun("inv err", 1, O_ERR_BUSY);
        expectRun("inv clc", 1, O_CLC);
        expectRun("inv wait_rel", 2, O_BUSY);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        expectRun("inv back idle", 2, O_IDLE);

        // Abort at pour cycle 10 (drink 1)
        $display("[TB] abort mid-pour");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        payPhase("abort pay");
        expectRun("abort cup", 4, O_CUP);
        expectRun("abort pour", 10, O_POUR1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        expectRun("abort err", 1, O_ERR_IDLE);
        expectRun("abort idle no clc", 3, O_IDLE);

        // Async reset mid-pour (drink 3), then selection still held starts a new cycle
        $display("[TB] reset mid-pour");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        payPhase("rst pay");
        expectRun("rst cup", 4, O_CUP);
        expectRun("rst pour", 5, O_POUR3);
        reset = 1'b1;
        #1;
        checkOutput("async reset outputs", O_IDLE);
        #1;
        reset = 1'b0;
        payPhase("rst2 pay");
        expectRun("rst2 cup", 4, O_CUP);
        expectRun("rst2 pour", 40, O_POUR3);
        expectRun("rst2 drip+ack", 7, O_BUSY);
        expectRun("rst2 clc", 1, O_CLC);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        expectRun("rst2 back idle", 2, O_IDLE);

`ifdef COIN_CHECK_EN
        $display("[TB] payment timeout");
        coin_ok = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        expectRun("pay wait", 100, O_BUSY);
        expectRun("pay timeout err", 1, O_ERR_BUSY);
        expectRun("pay timeout clc", 1, O_CLC);
        applyStimulus(1'b0, 1'b0, 1'b0, 0);
        expectRun("pay timeout idle", 2, O_IDLE);

        $display("[TB] coin after 5 cycles");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        expectRun("coin pay", 5, O_BUSY);
        coin_ok = 1'b1;
        expectRun("coin cup", 4, O_CUP);
        expectRun("coin pour", 2, O_POUR2);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        expectRun("coin abort err", 1, O_ERR_IDLE);
        expectRun("coin idle", 2, O_IDLE);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
